addsub_pipe_stage: RTL

- Two-stage, valid/ready pipelined front end for the calculator's 64-bit add/subtract datapath.
- Stage 1 registers the incoming operand request.
- A combinational 64-bit add/sub core computes the result and flags from the stage-1 registers.
- Stage 2 registers the result and flags for the downstream consumer (display/writeback). Also keeps an operation counter and a sticky overflow flag for the calculator status logic.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/addsub64_core.sv | 31 +++
 rtl/addsub_pipe_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the 64-bit add/subtract pipeline front end.
package addsub_pkg;

    localparam int DEFAULT_WIDTH = 64;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic sf;
        logic cf;
        logic of;
        logic pf;
        logic zf;
    } addsub_flags_t;

    // Even parity of a byte: 1 when the byte holds an even number of ones.
    function automatic logic even_parity8(input logic [7:0] v);
        return ~(^v);
    endfunction

endpackage

// File: rtl/addsub64_core.sv
// Combinational add/subtract core with status flag generation.
module addsub64_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] result,
    output addsub_flags_t    flags
);

    logic             sub_s;
    logic [WIDTH-1:0] b_x_s;
    logic [WIDTH:0]   full_s;

    // Subtract is A + ~B + 1; carry out of the top bit is the CF (no-borrow for subtract).
    always_comb begin
        sub_s    = (mode == MODE_SUB);
        b_x_s    = b ^ {WIDTH{sub_s}};
        full_s   = {1'b0, a} + {1'b0, b_x_s} + {{WIDTH{1'b0}}, sub_s};
        result   = full_s[WIDTH-1:0];
        flags.sf = full_s[WIDTH-1];
        flags.cf = full_s[WIDTH];
        flags.of = (a[WIDTH-1] == b_x_s[WIDTH-1]) && (full_s[WIDTH-1] != a[WIDTH-1]);
        flags.pf = even_parity8(full_s[7:0]);
        flags.zf = (full_s[WIDTH-1:0] == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/addsub_pipe_stage.sv
// Two-stage valid/ready pipeline around the add/sub core, with op counter and sticky overflow.
module addsub_pipe_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_sf,
    output logic             out_cf,
    output logic             out_of,
    output logic             out_pf,
    output logic             out_zf,
    input  logic             clr_sticky,
    output logic             sticky_of,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_mode_q, s1_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    addsub_flags_t    flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    logic             s2_adv_s, s1_adv_s, in_xfer_s, out_xfer_s;
    logic [WIDTH-1:0] core_res_s;
    addsub_flags_t    core_flags_s;

    addsub64_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .mode   (s1_mode_q),
        .result (core_res_s),
        .flags  (core_flags_s)
    );

    // Handshake control: a stage advances when its successor is empty or draining.
    always_comb begin
        s2_adv_s   = !out_valid_q || out_ready;
        s1_adv_s   = !s1_valid_q || s2_adv_s;
        in_xfer_s  = in_valid && s1_adv_s;
        out_xfer_s = out_valid_q && out_ready;
    end

    // Next-state for both stages, the op counter and the sticky overflow flag.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;

        if (s1_adv_s) begin
            s1_valid_d = in_xfer_s;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (in_xfer_s) begin
            s1_a_d    = in_a;
            s1_b_d    = in_b;
            s1_mode_d = in_mode;
        end else begin
            s1_a_d    = s1_a_q;
        end

        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d   = core_res_s;
                flags_d = core_flags_s;
            end else begin
                res_d   = res_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end

        if (out_xfer_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        // A setting transfer takes priority over a same-cycle clear.
        if (out_xfer_s && flags_q.of) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers with synchronous reset; in-flight requests are simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {WIDTH{1'b0}};
            s1_b_q      <= {WIDTH{1'b0}};
            s1_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= {WIDTH{1'b0}};
            flags_q     <= '{sf: 1'b0, cf: 1'b0, of: 1'b0, pf: 1'b0, zf: 1'b0};
            cnt_q       <= {CNT_W{1'b0}};
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
        end
    end

    // Output drive; in_ready is deliberately combinational from out_ready (no skid buffer).
    always_comb begin
        in_ready   = s1_adv_s;
        out_valid  = out_valid_q;
        out_result = res_q;
        out_sf     = flags_q.sf;
        out_cf     = flags_q.cf;
        out_of     = flags_q.of;
        out_pf     = flags_q.pf;
        out_zf     = flags_q.zf;
        sticky_of  = sticky_q;
        op_count   = cnt_q;
    end

endmodule
